// File: rtl/ss_result_framer.sv
// Result framer: stages the 40-bit result stream, buffers it in a FIFO and emits it as MSB-first bytes.
// Optional trailing XOR checksum byte per frame when SS_FRAMER_CHECKSUM_EN is defined.
module ss_result_framer #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [39:0]              in_value,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic                     out_last,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   PtrOne    = (AW+1)'(1);
  localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] IdxOne    = AW'(1);

`ifdef SS_FRAMER_CHECKSUM_EN
  typedef enum logic [1:0] {StEmpty, StSend, StCsum} state_e;
`else
  typedef enum logic [1:0] {StEmpty, StSend} state_e;
`endif

  logic [39:0]   stage_q;
  logic          stage_vld_q;
  logic [40:0]   mem [DEPTH];
  logic [AW:0]   wptr_q, rptr_q, count;
  logic          overflow_q;
  state_e        state_q;
  logic [2:0]    idx_q;
  logic [40:0]   hold_q;
  logic          empty, full, push, pop, push_ok, drop, xfer, last_byte;
  logic [40:0]   push_entry, head;
  logic [AW-1:0] tail_idx;

  assign count      = wptr_q - rptr_q;
  assign empty      = (count == '0);
  assign full       = (count == FullCount);
  assign push       = stage_vld_q;
  assign push_entry = {~in_valid, stage_q};
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign head       = mem[rptr_q[AW-1:0]];
  assign tail_idx   = wptr_q[AW-1:0] - IdxOne;
  assign xfer       = out_valid && out_ready;
  assign last_byte  = (idx_q == 3'd4);
  assign fifo_level = count;
  assign overflow   = overflow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
    end else begin
      stage_vld_q <= in_valid;
      if (in_valid) stage_q <= in_value;
    end
  end

  // A dropped end-of-burst marker is folded into the newest resident entry.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wptr_q[AW-1:0]] <= push_entry;
    end else if (drop && push_entry[40]) begin
      mem[tail_idx][40] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrOne;
      if (pop)     rptr_q <= rptr_q + PtrOne;
      if (drop)    overflow_q <= 1'b1;
    end
  end

  always_comb begin
    pop = 1'b0;
    case (state_q)
      StEmpty: pop = !empty;
`ifdef SS_FRAMER_CHECKSUM_EN
      StSend:  pop = xfer && last_byte && !hold_q[40] && !empty;
      StCsum:  pop = xfer && !empty;
`else
      StSend:  pop = xfer && last_byte && !empty;
`endif
      default: pop = 1'b0;
    endcase
  end

`ifdef SS_FRAMER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (xfer) begin
      csum_q <= (state_q == StCsum) ? 8'h00 : (csum_q ^ out_data);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      hold_q  <= '0;
    end else if (pop) begin
      hold_q  <= head;
      idx_q   <= '0;
      state_q <= StSend;
    end else begin
      case (state_q)
        StSend: begin
          if (xfer) begin
            if (!last_byte) begin
              idx_q <= idx_q + 3'd1;
            end else begin
`ifdef SS_FRAMER_CHECKSUM_EN
              state_q <= hold_q[40] ? StCsum : StEmpty;
`else
              state_q <= StEmpty;
`endif
            end
          end
        end
`ifdef SS_FRAMER_CHECKSUM_EN
        StCsum: if (xfer) state_q <= StEmpty;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    case (state_q)
      StSend: begin
        out_valid = 1'b1;
        case (idx_q)
          3'd0:    out_data = hold_q[39:32];
          3'd1:    out_data = hold_q[31:24];
          3'd2:    out_data = hold_q[23:16];
          3'd3:    out_data = hold_q[15:8];
          3'd4:    out_data = hold_q[7:0];
          default: out_data = '0;
        endcase
`ifdef SS_FRAMER_CHECKSUM_EN
        out_last = 1'b0;
`else
        out_last = hold_q[40] && last_byte;
`endif
      end
`ifdef SS_FRAMER_CHECKSUM_EN
      StCsum: begin
        out_valid = 1'b1;
        out_data  = csum_q;
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
